fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of async_fifo between N_REQ requesters in the write clock domain.
- Each requester presents beats on a valid/ready handshake.
- A grant is held for one packet, capped at MAX_BURST beats, so that packets from different requesters are never interleaved in the FIFO.
- Sits directly in front of async_fifo: drives its w_en/i_dat and consumes its w_full/w_almost_full.

Parameters:
- N_REQ, 4, number of requesters; must be >= 1.
- DW, 4, data width; must equal the FIFO DW.
- MAX_BURST, 8, maximum beats per grant; must be >= 1.
- IW, $clog2(N_REQ) (minimum 1), width of the grant index; localparam.
- BW, $clog2(MAX_BURST) (minimum 1), width of the beat counter; localparam.

Ports:
- w_clk  in  1  write-domain clock (the only clock).
- w_rstn  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester beat valid.
- req_last  in  N_REQ  per-requester last beat of packet; qualified by req_valid.
- req_dat  in  N_REQ*DW  per-requester data; requester i uses bits [i*DW +: DW].
- req_ready  out  N_REQ  per-requester beat accepted this cycle.
- w_en  out  1  FIFO write enable.
- i_dat  out  DW  FIFO write data.
- w_full  in  1  FIFO full flag.
- w_almost_full  in  1  FIFO almost-full flag.
- gnt_active  out  1  a grant is currently held.
- gnt_id  out  IW  index of the granted requester; valid while gnt_active=1.

Behaviour:
- Reset (asynchronous, w_rstn=0):
  - state=IDLE, gnt_id=0, rr_ptr=0, beat_cnt=0.
  - gnt_active=0, w_en=0, req_ready=0, i_dat=0.
  - Reset mid-burst abandons the packet; any beats already written stay in the FIFO.
- States: IDLE and BURST.
- IDLE:
  - If any req_valid bit is set, select the first set bit searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ..., N_REQ-1, 0, ...).
  - Register the selection into gnt_id, clear beat_cnt, set gnt_active=1, go to BURST.
  - No beat is accepted in IDLE. Minimum request-to-first-write latency is 1 cycle.
- BURST:
  - accept = req_valid[gnt_id] & ~w_full.
  - Combinational outputs: w_en = accept; req_ready[gnt_id] = ~w_full (all other bits 0); i_dat = req_dat[gnt_id] whenever gnt_active=1, otherwise 0.
  - On accept, beat_cnt increments.
  - The burst ends on an accepted beat when req_last[gnt_id]=1 or beat_cnt==MAX_BURST-1. On end: rr_ptr = (gnt_id+1) mod N_REQ, beat_cnt=0, gnt_active=0, go to IDLE.
  - One idle cycle always separates consecutive grants.
- w_full=1 during BURST: no write, req_ready=0, beat_cnt holds, grant holds; resume the cycle after w_full drops.
- req_valid[gnt_id] drops mid-packet (no last seen): grant is held indefinitely. Packet atomicity takes priority; requesters must not stall forever mid-packet.
- A MAX_BURST cut without last: the remainder of the packet is granted again later as a new burst. Interleaving with other requesters is then allowed.
- Wrap-around: gnt_id=N_REQ-1 leads to rr_ptr=0.
- N_REQ=1: always grants requester 0.
- Simultaneous req_last and MAX_BURST limit on the same beat: single end-of-burst, no double advance.
- Lost-write invariant: never w_en=1 while w_full=1.

Optional Feature:
- Macro FIFO_WR_ARB_AF_THROTTLE_EN.
- Defined: IDLE issues no new grant while w_almost_full=1, so a burst never starts near full. A burst already in progress continues until w_full.
- Undefined: w_almost_full is ignored and grants start regardless. The port remains present but is unused.

Test Plan:
- All 4 req_valid=1, single-beat packets (req_last=1), FIFO empty: grants in order 0,1,2,3,0. FIFO contents match the per-requester data order. Exactly one write every 2 cycles.
- Requester 2 sends a 3-beat packet while requester 1 is also valid: beats 2a,2b,2c are written contiguously with req_ready[1]=0 throughout. Requester 1 is granted next, 1 idle cycle after 2c.
- Requester 0 sends 20 beats, no last, MAX_BURST=8, requester 3 valid: writes occur as 8 from requester 0, then 3's packet, then 8 from 0, then 3, then 4 from 0.
- w_full forced to 1 for 5 cycles mid-burst after beat 2: w_en=0 and req_ready=0 for those 5 cycles, beat_cnt stays 2, no data lost or duplicated.
- w_rstn pulsed low mid-burst: all outputs 0 immediately, asynchronously. After release the first grant goes to the lowest-index valid requester (rr_ptr=0).
- With FIFO_WR_ARB_AF_THROTTLE_EN defined, w_almost_full=1 and req_valid=4'b0001: gnt_active stays 0 until w_almost_full=0, then grants the next cycle. With the macro undefined, the grant is issued immediately.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that shares the async_fifo write port
// between N_REQ valid/ready requesters. A grant covers one packet and is cut
// after MAX_BURST beats, so packets from different requesters never interleave.
// Optional build macro FIFO_WR_ARB_AF_THROTTLE_EN: when defined, no new grant is
// issued while w_almost_full is high; when undefined, w_almost_full is unused.
module fifo_wr_arbiter #(
  parameter  int N_REQ     = 4,
  parameter  int DW        = 4,
  parameter  int MAX_BURST = 8,
  localparam int IW        = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int BW        = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
  input  logic              w_clk,
  input  logic              w_rstn,
  input  logic [N_REQ-1:0]  req_valid,
  input  logic [N_REQ-1:0]  req_last,
  input  logic [N_REQ*DW-1:0] req_dat,
  output logic [N_REQ-1:0]  req_ready,
  output logic              w_en,
  output logic [DW-1:0]     i_dat,
  input  logic              w_full,
  input  logic              w_almost_full,
  output logic              gnt_active,
  output logic [IW-1:0]     gnt_id
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   gnt_id_nxt;
  logic [IW-1:0]   rr_ptr, rr_ptr_nxt;
  logic [BW-1:0]   beat_cnt, beat_cnt_nxt;
  logic            sel_found;
  logic [IW-1:0]   sel_idx;
  logic            start_ok;
  logic            accept;
  logic            burst_end;

  // Pick the first valid requester searching upward from rr_ptr with wrap.
  always_comb begin
    int unsigned k;
    sel_found = 1'b0;
    sel_idx   = '0;
    k         = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      k = (32'(rr_ptr) + i) % N_REQ;
      if (!sel_found && req_valid[k]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(k);
      end
    end
  end

`ifdef FIFO_WR_ARB_AF_THROTTLE_EN
  assign start_ok = sel_found & ~w_almost_full;
`else
  logic unused_af;
  assign unused_af = w_almost_full;
  assign start_ok  = sel_found;
`endif

  assign accept    = (state == BURST) & req_valid[gnt_id] & ~w_full;
  // A beat carrying req_last on the MAX_BURST-th beat still ends the burst once.
  assign burst_end = accept & (req_last[gnt_id] | (beat_cnt == BW'(MAX_BURST - 1)));

  // Next-state logic and the combinational FIFO/requester-facing outputs.
  always_comb begin
    state_nxt    = state;
    gnt_id_nxt   = gnt_id;
    rr_ptr_nxt   = rr_ptr;
    beat_cnt_nxt = beat_cnt;
    req_ready    = '0;
    w_en         = 1'b0;
    i_dat        = '0;
    gnt_active   = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) begin
          gnt_id_nxt   = sel_idx;
          beat_cnt_nxt = '0;
          state_nxt    = BURST;
        end
      end
      BURST: begin
        gnt_active        = 1'b1;
        i_dat             = req_dat[gnt_id*DW +: DW];
        req_ready[gnt_id] = ~w_full;
        w_en              = accept;
        if (burst_end) begin
          beat_cnt_nxt = '0;
          rr_ptr_nxt   = (gnt_id == IW'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
          state_nxt    = IDLE;
        end else if (accept) begin
          beat_cnt_nxt = beat_cnt + 1'b1;
        end
      end
    endcase
  end

  // State, grant and pointer registers with asynchronous active-low reset.
  always_ff @(posedge w_clk or negedge w_rstn) begin
    if (!w_rstn) begin
      state    <= IDLE;
      gnt_id   <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      gnt_id   <= gnt_id_nxt;
      rr_ptr   <= rr_ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: vector table, directed corner sequences and
// randomized packet traffic checked against a packet-level round-robin model.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 4;
  localparam int MB = 8;

  logic            w_clk = 1'b0;
  logic            w_rstn;
  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [N*DW-1:0] req_dat;
  logic            w_en;
  logic [DW-1:0]   i_dat;
  logic            w_full, w_almost_full;
  logic            gnt_active;
  logic [1:0]      gnt_id;

  fifo_wr_arbiter #(.N_REQ(N), .DW(DW), .MAX_BURST(MB)) dut (
    .w_clk(w_clk), .w_rstn(w_rstn), .req_valid(req_valid), .req_last(req_last),
    .req_dat(req_dat), .req_ready(req_ready), .w_en(w_en), .i_dat(i_dat),
    .w_full(w_full), .w_almost_full(w_almost_full), .gnt_active(gnt_active),
    .gnt_id(gnt_id)
  );

  always #5 w_clk = ~w_clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed { logic [DW-1:0] dat; logic last; } beat_t;
  typedef struct packed { logic [1:0] id; logic [DW-1:0] dat; } wr_t;
  beat_t drv_q[N][$];
  wr_t   exp_q[$];

  typedef struct {
    logic [N-1:0]  valid;
    logic [N-1:0]  last;
    logic          exp_act;
    logic [1:0]    exp_id;
    logic          exp_wen;
    logic [N-1:0]  exp_rdy;
    logic [DW-1:0] exp_dat;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l,
                       input logic [N*DW-1:0] d, input logic f, input logic af);
    @(negedge w_clk);
    req_valid = v; req_last = l; req_dat = d; w_full = f; w_almost_full = af;
    #1;
  endtask

  task automatic reset_dut();
    @(negedge w_clk);
    w_rstn = 1'b0;
    req_valid = '0; req_last = '0; req_dat = '0; w_full = 1'b0; w_almost_full = 1'b0;
    @(negedge w_clk);
    w_rstn = 1'b1;
  endtask

  // Packet-level reference: whenever the port is free, the next requester with
  // pending beats (searching from the pointer) sends up to MB beats of its packet.
  task automatic build_expected();
    beat_t m[N][$];
    int rr, id;
    beat_t x;
    rr = 0;
    exp_q.delete();
    for (int i = 0; i < N; i++) m[i] = drv_q[i];
    while (1) begin
      id = -1;
      for (int k = 0; k < N; k++)
        if (id < 0 && m[(rr + k) % N].size() > 0) id = (rr + k) % N;
      if (id < 0) break;
      for (int b = 0; b < MB; b++) begin
        if (m[id].size() == 0) break;
        x = m[id].pop_front();
        exp_q.push_back({id[1:0], x.dat});
        if (x.last) break;
      end
      rr = (id + 1) % N;
    end
  endtask

  // Requesters stay valid while they hold beats; every FIFO write is scored.
  task automatic run_scenario(input string tag, input bit rand_full, input int budget);
    int cyc;
    wr_t e;
    cyc = 0;
    build_expected();
    while (exp_q.size() > 0 && cyc < budget) begin
      @(negedge w_clk);
      w_full        = rand_full ? ($urandom_range(0, 3) == 0) : 1'b0;
      w_almost_full = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) begin
        req_valid[i] = (drv_q[i].size() > 0);
        req_dat[i*DW +: DW] = req_valid[i] ? drv_q[i][0].dat : '0;
        req_last[i] = req_valid[i] ? drv_q[i][0].last : 1'b0;
      end
      #1;
      chk({tag, "_wen_hs"}, 32'(w_en), 32'(|(req_valid & req_ready)));
      if (w_en) begin
        chk({tag, "_no_wr_full"}, 32'(w_full), 32'd0);
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL %s_extra_write: got id %0d dat %0h expected no write", tag, gnt_id, i_dat);
        end else begin
          e = exp_q.pop_front();
          chk({tag, "_wr_id"}, 32'(gnt_id), 32'(e.id));
          chk({tag, "_wr_dat"}, 32'(i_dat), 32'(e.dat));
        end
      end
      for (int i = 0; i < N; i++)
        if (req_valid[i] && req_ready[i]) void'(drv_q[i].pop_front());
      cyc++;
    end
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    @(negedge w_clk);
    req_valid = '0; req_last = '0; w_full = 1'b0; w_almost_full = 1'b0;
    for (int i = 0; i < N; i++) drv_q[i].delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, np;
    // Vector table: all requesters valid with single-beat packets.
    for (int k = 0; k < 5; k++) begin
      tbl[2*k]   = '{4'b1111, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000, 4'h0};
      tbl[2*k+1] = '{4'b1111, 4'b1111, 1'b1, 2'(k % 4), 1'b1,
                     4'(1 << (k % 4)), 4'(5 + (k % 4))};
    end

    w_rstn = 1'b0;
    req_valid = '0; req_last = '0; req_dat = '0; w_full = 1'b0; w_almost_full = 1'b0;
    #1;
    chk("rst_gnt_active", 32'(gnt_active), 32'd0);
    chk("rst_w_en", 32'(w_en), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_i_dat", 32'(i_dat), 32'd0);
    @(negedge w_clk);
    w_rstn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].valid, tbl[i].last, 16'h8765, 1'b0, 1'b0);
      chk($sformatf("tbl%0d_act", i), 32'(gnt_active), 32'(tbl[i].exp_act));
      if (tbl[i].exp_act) chk($sformatf("tbl%0d_id", i), 32'(gnt_id), 32'(tbl[i].exp_id));
      chk($sformatf("tbl%0d_wen", i), 32'(w_en), 32'(tbl[i].exp_wen));
      chk($sformatf("tbl%0d_rdy", i), 32'(req_ready), 32'(tbl[i].exp_rdy));
      chk($sformatf("tbl%0d_dat", i), 32'(i_dat), 32'(tbl[i].exp_dat));
    end

    // Asynchronous reset in the middle of a burst.
    drive(4'b1111, 4'b0000, 16'h8765, 1'b0, 1'b0);
    drive(4'b1111, 4'b0000, 16'h8765, 1'b0, 1'b0);
    chk("pre_rst_act", 32'(gnt_active), 32'd1);
    chk("pre_rst_id", 32'(gnt_id), 32'd1);
    #1 w_rstn = 1'b0;
    req_valid = '0;
    #1;
    chk("async_rst_act", 32'(gnt_active), 32'd0);
    chk("async_rst_wen", 32'(w_en), 32'd0);
    chk("async_rst_rdy", 32'(req_ready), 32'd0);
    chk("async_rst_dat", 32'(i_dat), 32'd0);
    @(negedge w_clk);
    w_rstn = 1'b1;
    drive(4'b0011, 4'b0011, 16'h0000, 1'b0, 1'b0);
    chk("post_rst_idle", 32'(gnt_active), 32'd0);
    drive(4'b0011, 4'b0011, 16'h0000, 1'b0, 1'b0);
    chk("post_rst_act", 32'(gnt_active), 32'd1);
    chk("post_rst_rr0", 32'(gnt_id), 32'd0);

    // Requester 2 sends a 3-beat packet while requester 1 waits.
    drive(4'b0100, 4'b0000, 16'h0A00, 1'b0, 1'b0);
    chk("pkt_idle", 32'(gnt_active), 32'd0);
    drive(4'b0110, 4'b0000, 16'h0A10, 1'b0, 1'b0);
    chk("pkt_a_wen", 32'(w_en), 32'd1);
    chk("pkt_a_dat", 32'(i_dat), 32'hA);
    chk("pkt_a_rdy", 32'(req_ready), 32'b0100);
    drive(4'b0110, 4'b0000, 16'h0B10, 1'b0, 1'b0);
    chk("pkt_b_wen", 32'(w_en), 32'd1);
    chk("pkt_b_dat", 32'(i_dat), 32'hB);
    chk("pkt_b_rdy", 32'(req_ready), 32'b0100);
    drive(4'b0110, 4'b0100, 16'h0C10, 1'b0, 1'b0);
    chk("pkt_c_wen", 32'(w_en), 32'd1);
    chk("pkt_c_dat", 32'(i_dat), 32'hC);
    chk("pkt_c_rdy", 32'(req_ready), 32'b0100);
    drive(4'b0010, 4'b0010, 16'h0010, 1'b0, 1'b0);
    chk("pkt_gap_act", 32'(gnt_active), 32'd0);
    chk("pkt_gap_wen", 32'(w_en), 32'd0);
    drive(4'b0010, 4'b0010, 16'h0010, 1'b0, 1'b0);
    chk("pkt_next_act", 32'(gnt_active), 32'd1);
    chk("pkt_next_id", 32'(gnt_id), 32'd1);
    chk("pkt_next_wen", 32'(w_en), 32'd1);

    // FIFO full for 5 cycles after the second beat.
    drive(4'b0010, 4'b0000, 16'h0010, 1'b0, 1'b0);
    chk("full_idle", 32'(gnt_active), 32'd0);
    drive(4'b0010, 4'b0000, 16'h0010, 1'b0, 1'b0);
    chk("full_b1_wen", 32'(w_en), 32'd1);
    chk("full_b1_dat", 32'(i_dat), 32'h1);
    drive(4'b0010, 4'b0000, 16'h0020, 1'b0, 1'b0);
    chk("full_b2_wen", 32'(w_en), 32'd1);
    chk("full_b2_dat", 32'(i_dat), 32'h2);
    for (int c = 0; c < 5; c++) begin
      drive(4'b0010, 4'b0000, 16'h0030, 1'b1, 1'b0);
      chk($sformatf("full%0d_wen", c), 32'(w_en), 32'd0);
      chk($sformatf("full%0d_rdy", c), 32'(req_ready), 32'd0);
      chk($sformatf("full%0d_act", c), 32'(gnt_active), 32'd1);
      chk($sformatf("full%0d_cnt", c), 32'(dut.beat_cnt), 32'd2);
    end
    drive(4'b0010, 4'b0010, 16'h0030, 1'b0, 1'b0);
    chk("full_b3_wen", 32'(w_en), 32'd1);
    chk("full_b3_dat", 32'(i_dat), 32'h3);
    chk("full_b3_rdy", 32'(req_ready), 32'b0010);
    drive(4'b0000, 4'b0000, 16'h0000, 1'b0, 1'b0);
    chk("full_end_act", 32'(gnt_active), 32'd0);
    chk("full_end_cnt", 32'(dut.beat_cnt), 32'd0);

    // 20-beat packet from requester 0 cut at MAX_BURST, interleaved with requester 3.
    reset_dut();
    for (int b = 0; b < 20; b++) drv_q[0].push_back({4'(b), (b == 19)});
    for (int p = 0; p < 2; p++) begin
      drv_q[3].push_back({4'hE, 1'b0});
      drv_q[3].push_back({4'hF, 1'b1});
    end
    run_scenario("maxburst", 1'b0, 200);

    // Randomized packets with random back-pressure.
    for (int it = 0; it < 20; it++) begin
      reset_dut();
      for (int i = 0; i < N; i++) begin
        np = $urandom_range(0, 3);
        for (int p = 0; p < np; p++) begin
          len = $urandom_range(1, 12);
          for (int b = 0; b < len; b++)
            drv_q[i].push_back({4'($urandom_range(0, 15)), (b == len - 1)});
        end
      end
      run_scenario($sformatf("rand%0d", it), 1'b1, 2000);
    end

    // Almost-full behaviour at grant time.
    reset_dut();
`ifdef FIFO_WR_ARB_AF_THROTTLE_EN
    for (int c = 0; c < 3; c++) begin
      drive(4'b0001, 4'b0001, 16'h0009, 1'b0, 1'b1);
      chk($sformatf("af_hold%0d", c), 32'(gnt_active), 32'd0);
    end
    drive(4'b0001, 4'b0001, 16'h0009, 1'b0, 1'b1);
    chk("af_hold3", 32'(gnt_active), 32'd0);
    drive(4'b0001, 4'b0001, 16'h0009, 1'b0, 1'b0);
    chk("af_release_idle", 32'(gnt_active), 32'd0);
    drive(4'b0001, 4'b0001, 16'h0009, 1'b0, 1'b0);
    chk("af_grant_act", 32'(gnt_active), 32'd1);
    chk("af_grant_wen", 32'(w_en), 32'd1);
`else
    drive(4'b0001, 4'b0001, 16'h0009, 1'b0, 1'b1);
    chk("af_ignored_idle", 32'(gnt_active), 32'd0);
    drive(4'b0001, 4'b0001, 16'h0009, 1'b0, 1'b1);
    chk("af_ignored_act", 32'(gnt_active), 32'd1);
    chk("af_ignored_wen", 32'(w_en), 32'd1);
    chk("af_ignored_dat", 32'(i_dat), 32'h9);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
